fp8_mul_arbiter: RTL and testbench
==================================

# fp8_mul_arbiter

Two-requester round-robin arbiter that shares a single FP8VectorMul instance, which multiplies one FP8 scalar `q` by four FP8 lanes `vec` and returns four FP16 products `res`. It accepts operand jobs over valid/ready and drives the multiplier operand registers. It tags each issued job through a pipeline matched to the multiplier latency, then routes each result into a per-requester result FIFO with valid/ready output. It sits between the PE-level requesters and FP8VectorMul, which is instantiated beside it in the parent.

## Interface
- `MUL_LATENCY`, 2: cycles from the first cycle operands appear on `mul_*` to the cycle the matching `mul_res` is valid. Must be ≥1 and equal the multiplier pipeline depth.
- `RES_DEPTH`, 4: per-requester result FIFO depth, power of 2, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: job offered, bit i = requester i.
- `req_ready` out 2: job accepted this cycle.
- `req_e5m2` in 2: per-requester format select, 0 = E4M3, 1 = E5M2.
- `req_q` in 16: `{q1,q0}`, FP8 scalar per requester.
- `req_vec` in 64: `{vec1,vec0}`, four FP8 lanes per requester, lane 0 in the LSBs.
- `rsp_valid` out 2: result available.
- `rsp_ready` in 2: result consumed.
- `rsp_res` out 128: `{res1,res0}`, four FP16 products per requester, lane 0 in the LSBs.
- `mul_e5m2mode` out 1, `mul_q` out 8, `mul_vec` out 32: registered operands to FP8VectorMul.
- `mul_res` in 64: FP8VectorMul output.

## Operation
- **Credits.** `used[i]` (registered, 0..RES_DEPTH) counts jobs granted but not yet popped.
  - +1 on grant, −1 on `rsp_valid[i] && rsp_ready[i]`; both in the same cycle leaves it unchanged.
- **Eligibility.** Requester i is eligible when `req_valid[i] && used[i] < RES_DEPTH`, evaluated on the registered `used`.
- **Arbitration.**
  - At most one grant per cycle, and `req_ready` is one-hot or zero. `req_ready[i]` is combinational from `req_valid` and registered state.
  - Priority pointer `prio` (1 bit): the requester named by `prio` wins a tie.
  - After a grant to i, `prio` becomes the other requester. With no grant, `prio` is unchanged.
- **Issue.**
  - On a grant, `mul_q`/`mul_vec`/`mul_e5m2mode` register the winner's operands for exactly one cycle.
  - In any cycle without a grant, the next-cycle `mul_*` are all zero.
- **Tag pipeline.** `MUL_LATENCY+1` stages of `{valid, id}`. Stage 0 is loaded at grant; the last stage aligns with the cycle `mul_res` is valid.
- **Result write.** In that cycle, `mul_res` is written into FIFO[id]. Credits guarantee the FIFO never overflows, so no full check is applied on write.
- **FIFO read.** `rsp_valid[i]` means FIFO i is non-empty, and `rsp_res` shows its head. Per-requester results come out in grant order.
- **Reset.**
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_res=0`, `mul_*=0`.
  - State: `prio=0`, all `used=0`, all tag valids 0, FIFOs empty.
  - Reset mid-operation discards in-flight jobs: a `mul_res` arriving afterwards is ignored because its tags are cleared.

## Timing
- Handshake at cycle t.
  - `mul_*` hold the operands in cycle t+1.
  - `mul_res` is valid in cycle t+1+MUL_LATENCY and written at the end of that cycle.
  - `rsp_valid` rises in cycle t+2+MUL_LATENCY.
- Minimum request-to-response latency is MUL_LATENCY+2 cycles, so 4 with defaults.
- Throughput: one job per cycle in aggregate. With both requesters always eligible, grants alternate strictly.
- A pop in cycle t frees a credit that is usable for a grant in cycle t+1, not in cycle t.
- Push and pop on the same FIFO in the same cycle are both performed.

## Structure
- Package `fp8_arb_pkg` holds:
  - `N_REQ=2`, `FP8_W=8`, `FP16_W=16`, `LANES=4`.
  - Derived widths `VEC_W=32` and `RES_W=64`.
  - Typedef for the tag struct `{valid, id}`.
- Sub-module `fp8_res_fifo`: synchronous FIFO with synchronous active-high reset, instantiated once per requester.
  - Parameters: width `RES_W`, depth `RES_DEPTH`.
  - Ports: push, pop, `empty`, `count`, head data.

## Test plan
- **Single job, E4M3, defaults.** Requester 0 sends q=0x3C, vec=0xC840C43C → `rsp_valid[0]` rises exactly 4 cycles after the handshake with `rsp_res[63:0]`=0xC600_4200_C480_4080 (+2.25, −4.5, +3.0, −6.0). `rsp_valid[1]` stays 0.
- **Continuous contention.** Both requesters valid every cycle, `rsp_ready`=2'b11 → grants go 0,1,0,1,… starting with 0 after reset. Each port receives only its own results, in order, with no bubbles after the pipeline fills.
- **Backpressure.** `rsp_ready[1]`=0, requester 1 always valid → exactly 4 grants to requester 1, then `req_ready[1]` stays 0 while requester 0 is granted every cycle. Raising `rsp_ready[1]` drains 4 results in order, and the first new grant to requester 1 lands the cycle after the first pop.
- **Reset mid-flight.** Issue two jobs, then assert `rst` for one cycle on the cycle after the second handshake → every output is 0 in the following cycle, no `rsp_valid` ever appears for those jobs, and the next contended grant goes to requester 0.
- **Format routing.** Requester 1 sends a job with `req_e5m2`=1 → `mul_e5m2mode`=1 for exactly one cycle. `mul_*` are zero on idle cycles before and after.

Source files
------------

// File: rtl/fp8_arb_pkg.sv
// Shared widths and the result-routing tag for the FP8 multiplier arbiter.
package fp8_arb_pkg;
  localparam int N_REQ  = 2;
  localparam int FP8_W  = 8;
  localparam int FP16_W = 16;
  localparam int LANES  = 4;
  localparam int VEC_W  = FP8_W * LANES;
  localparam int RES_W  = FP16_W * LANES;

  typedef struct packed {
    logic       valid;
    logic [0:0] id;
  } tag_t;
endpackage

// File: rtl/fp8_res_fifo.sv
// Per-requester result FIFO; head is raw storage, callers qualify it with count.
module fp8_res_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr, rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push)          wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr[AW-1:0]] <= din;
  end

  assign count = wr - rd;
  assign empty = (wr == rd);
  assign head  = mem[rd[AW-1:0]];
endmodule

// File: rtl/fp8_mul_arbiter.sv
// Round-robin sharing of one FP8VectorMul between two requesters, with
// credit-limited issue and tagged return into per-requester result FIFOs.
module fp8_mul_arbiter
  import fp8_arb_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int RES_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             req_e5m2,
  input  logic [N_REQ-1:0][FP8_W-1:0]  req_q,
  input  logic [N_REQ-1:0][VEC_W-1:0]  req_vec,
  output logic [N_REQ-1:0]             rsp_valid,
  input  logic [N_REQ-1:0]             rsp_ready,
  output logic [N_REQ-1:0][RES_W-1:0]  rsp_res,
  output logic                         mul_e5m2mode,
  output logic [FP8_W-1:0]             mul_q,
  output logic [VEC_W-1:0]             mul_vec,
  input  logic [RES_W-1:0]             mul_res
);
  localparam int UW = $clog2(RES_DEPTH + 1);
  localparam int CW = $clog2(RES_DEPTH) + 1;

  logic [N_REQ-1:0][UW-1:0]    used;
  logic                        prio;
  logic [N_REQ-1:0]            elig, push, pop, empty;
  logic [N_REQ-1:0][CW-1:0]    cnt;
  logic [N_REQ-1:0][RES_W-1:0] head;
  logic                        grant;
  logic                        gid;
  tag_t                        tag_pipe [MUL_LATENCY:0];

  // No grants while in reset so no credit or tag leaks across it.
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req_valid[i] && (used[i] < UW'(RES_DEPTH)) && !rst;
    grant     = |elig;
    gid       = elig[1] && (!elig[0] || prio);
    req_ready = '0;
    if (grant) req_ready[gid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      used         <= '0;
      mul_q        <= '0;
      mul_vec      <= '0;
      mul_e5m2mode <= 1'b0;
      for (int k = 0; k <= MUL_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      if (grant) prio <= !gid;
      mul_q        <= grant ? req_q[gid]   : '0;
      mul_vec      <= grant ? req_vec[gid] : '0;
      mul_e5m2mode <= grant && req_e5m2[gid];
      tag_pipe[0]  <= '{valid: grant, id: gid};
      for (int k = 1; k <= MUL_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      for (int i = 0; i < N_REQ; i++)
        used[i] <= used[i] + UW'(req_ready[i]) - UW'(pop[i]);
    end
  end

  // Last tag stage lines up with mul_res; credits make a full check unnecessary.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      push[i]      = tag_pipe[MUL_LATENCY].valid && (tag_pipe[MUL_LATENCY].id == 1'(i));
      rsp_valid[i] = !empty[i];
      pop[i]       = rsp_valid[i] && rsp_ready[i];
      rsp_res[i]   = (cnt[i] != '0) ? head[i] : '0;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    fp8_res_fifo #(.W(RES_W), .DEPTH(RES_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (mul_res),
      .pop   (pop[i]),
      .empty (empty[i]),
      .count (cnt[i]),
      .head  (head[i])
    );
  end
endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Directed + random bench for fp8_mul_arbiter with an FP8 multiplier stub and
// a queue-based reference model of credits, round-robin and response timing.
module tb_fp8_mul_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, req_e5m2, rsp_valid, rsp_ready;
  logic [15:0]  req_q;
  logic [63:0]  req_vec;
  logic [127:0] rsp_res;
  logic         mul_e5m2mode;
  logic [7:0]   mul_q;
  logic [31:0]  mul_vec;
  logic [63:0]  mul_res;

  int passed = 0, total = 0, fails = 0, cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          rdy;
  } ent_t;

  ent_t        mq [2][$];
  int          mused [2];
  logic        mprio;
  logic [7:0]  xq;
  logic [31:0] xvec;
  logic        xmode;

  always #5 clk = ~clk;

  fp8_mul_arbiter #(.MUL_LATENCY(2), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_e5m2(req_e5m2),
    .req_q(req_q), .req_vec(req_vec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .mul_e5m2mode(mul_e5m2mode), .mul_q(mul_q), .mul_vec(mul_vec), .mul_res(mul_res)
  );

  // FP8 x FP8 -> FP16 for normal operands (exact: products fit the FP16 mantissa).
  function automatic logic [15:0] fmul8(input logic m5, input logic [7:0] a, input logic [7:0] b);
    int          ea, eb, e, p;
    logic [9:0]  fr;
    if (!m5) begin
      ea = int'(a[6:3]); eb = int'(b[6:3]);
      p  = (8 + int'(a[2:0])) * (8 + int'(b[2:0]));
      e  = ea + eb - 14 + 15;
      if (p >= 128) begin e++; fr = {p[6:0], 3'b0}; end
      else          fr = {p[5:0], 4'b0};
    end else begin
      ea = int'(a[6:2]); eb = int'(b[6:2]);
      p  = (4 + int'(a[1:0])) * (4 + int'(b[1:0]));
      e  = ea + eb - 30 + 15;
      if (p >= 32) begin e++; fr = {p[4:0], 5'b0}; end
      else         fr = {p[3:0], 6'b0};
    end
    return {a[7] ^ b[7], e[4:0], fr};
  endfunction

  function automatic logic [63:0] vmul(input logic m5, input logic [7:0] q, input logic [31:0] v);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = fmul8(m5, q, v[l*8 +: 8]);
    return r;
  endfunction

  // Two-stage multiplier stand-in; keeps flowing through reset like the real one.
  logic [63:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= vmul(mul_e5m2mode, mul_q, mul_vec);
    s2 <= s1;
  end
  assign mul_res = s2;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mused[0] = 0; mused[1] = 0; mprio = 1'b0;
    mq[0].delete(); mq[1].delete();
  endtask

  // One clock cycle: drive, sample mid-cycle, compare against model, advance model.
  task automatic step(input logic [1:0] v, input logic [1:0] e, input logic [15:0] q,
                      input logic [63:0] vec, input logic [1:0] rr, input logic r);
    logic [1:0]   el, xr, xv;
    logic         g, gi;
    logic [127:0] xres;
    ent_t         ent;
    @(posedge clk); #1;
    req_valid = v; req_e5m2 = e; req_q = q; req_vec = vec; rsp_ready = rr; rst = r;
    #3;
    for (int i = 0; i < 2; i++) el[i] = v[i] && (mused[i] < 4) && !r;
    g  = |el;
    gi = el[1] && (!el[0] || mprio);
    xr = g ? (2'b01 << gi) : 2'b00;
    check("req_ready", 128'(req_ready), 128'(xr));
    check("mul_q", 128'(mul_q), 128'(xq));
    check("mul_vec", 128'(mul_vec), 128'(xvec));
    check("mul_e5m2mode", 128'(mul_e5m2mode), 128'(xmode));
    for (int i = 0; i < 2; i++) begin
      xv[i] = (mq[i].size() > 0) && (mq[i][0].rdy <= cyc);
      xres[i*64 +: 64] = xv[i] ? mq[i][0].res : 64'h0;
    end
    check("rsp_valid", 128'(rsp_valid), 128'(xv));
    check("rsp_res", rsp_res, xres);
    if (r) begin
      model_clear();
      xq = '0; xvec = '0; xmode = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (xv[i] && rr[i]) begin void'(mq[i].pop_front()); mused[i]--; end
      if (g) begin
        ent.res = vmul(e[gi], q[gi*8 +: 8], vec[gi*32 +: 32]);
        ent.rdy = cyc + 4;
        mq[gi].push_back(ent);
        mused[gi]++;
        mprio = !gi;
        xq = q[gi*8 +: 8]; xvec = vec[gi*32 +: 32]; xmode = e[gi];
      end else begin
        xq = '0; xvec = '0; xmode = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input logic [1:0] rr, input int n);
    for (int k = 0; k < n; k++) step(2'b00, 2'b00, 16'h0, 64'h0, rr, 1'b0);
  endtask

  task automatic both(input logic [1:0] rr, input int n);
    for (int k = 0; k < n; k++)
      step(2'b11, 2'(2'b00), 16'($urandom), {$urandom, $urandom}, rr, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_e5m2 = '0; req_q = '0; req_vec = '0; rsp_ready = '0;
    model_clear();
    xq = '0; xvec = '0; xmode = 1'b0;

    step(2'b00, 2'b00, 16'h0, 64'h0, 2'b00, 1'b1);
    step(2'b00, 2'b00, 16'h0, 64'h0, 2'b00, 1'b1);
    idle(2'b00, 2);

    // Single E4M3 job: response exactly four cycles after the handshake.
    step(2'b01, 2'b00, 16'h003C, 64'h0000_0000_C840_C43C, 2'b00, 1'b0);
    idle(2'b00, 3);
    step(2'b00, 2'b00, 16'h0, 64'h0, 2'b01, 1'b0);
    check("single_valid", 128'(rsp_valid), 128'(2'b01));
    check("single_res", 128'(rsp_res[63:0]), 128'(64'hC600_4200_C480_4080));
    idle(2'b11, 2);

    // E5M2 job from requester 1 drives the mode bit for a single cycle.
    step(2'b10, 2'b10, 16'h3C00, 64'h3C40_44C8_0000_0000, 2'b11, 1'b0);
    idle(2'b11, 1);
    check("fmt_mode_on", 128'(mul_e5m2mode), 128'(1'b1));
    idle(2'b11, 1);
    check("fmt_mode_off", 128'(mul_e5m2mode), 128'(1'b0));
    check("fmt_mul_idle", 128'({mul_q, mul_vec}), 128'(0));
    idle(2'b11, 4);

    // Continuous contention, then backpressure on requester 1, then drain.
    both(2'b11, 20);
    both(2'b01, 14);
    both(2'b11, 14);
    idle(2'b11, 8);

    // Reset one cycle after the second handshake discards both jobs.
    step(2'b01, 2'b00, 16'h003C, 64'h0000_0000_3C3C_3C3C, 2'b11, 1'b0);
    step(2'b10, 2'b00, 16'h3C00, 64'h4040_4040_0000_0000, 2'b11, 1'b0);
    step(2'b00, 2'b00, 16'h0, 64'h0, 2'b11, 1'b1);
    idle(2'b11, 1);
    check("rst_outputs", {rsp_res[63:0], 8'(rsp_valid), 8'(req_ready), 8'(mul_e5m2mode), 8'(mul_q), mul_vec},
          128'(0));
    idle(2'b11, 6);
    step(2'b11, 2'b00, 16'h1234, 64'h0123_4567_89AB_CDEF, 2'b11, 1'b0);
    check("rst_first_grant", 128'(req_ready), 128'(2'b01));
    idle(2'b11, 6);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++)
      step(2'($urandom), 2'($urandom), 16'($urandom), {$urandom, $urandom},
           2'($urandom), ($urandom_range(0, 63) == 0));
    idle(2'b11, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
